serial_lu: RTL and testbench

//   Bit-serial logic unit. Drives a one-bit logic cell (and/or/xor/not-a) one bit per cycle.

---
 rtl/serial_lu_if.sv | 22 ++
 rtl/serial_lu.sv | 108 ++++++++++
 tb/tb_serial_lu.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/serial_lu_if.sv
// Handshake and data bundle between a requester and the bit-serial logic unit.
interface serial_lu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, a, b, op,
    input  busy, done, result
  );

  modport slave (
    input  start, a, b, op,
    output busy, done, result
  );
endinterface

// File: rtl/serial_lu.sv
// Bit-serial logic unit: latches two operands and an op, then pushes them
// LSB-first through a one-bit logic cell, assembling the result MSB-in.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands latched on the accepting edge
// SHIFT | one operand bit per cycle through the cell, busy=1
// DONE  | result valid, done=1 for one cycle, start ignored
module serial_lu #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  serial_lu_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       op_reg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] result_reg;
  logic             cell_bit;
  logic             last_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // One-bit logic cell evaluated on the current operand LSBs.
  always_comb begin
    cell_bit = 1'b0;
    case (op_reg)
      2'b00:   cell_bit = a_reg[0] & b_reg[0];
      2'b01:   cell_bit = a_reg[0] | b_reg[0];
      2'b10:   cell_bit = a_reg[0] ^ b_reg[0];
      default: cell_bit = ~a_reg[0];
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; DONE always falls back to IDLE so start is never taken there.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last_bit)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded straight from the state flops.
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      SHIFT:   bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture in IDLE, shift and result assembly in SHIFT,
  // everything held otherwise so result stays stable after done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= 2'b00;
      cnt        <= '0;
      result_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg  <= bus.a;
            b_reg  <= bus.b;
            op_reg <= bus.op;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          result_reg <= {cell_bit, result_reg[WIDTH-1:1]};
          a_reg      <= a_reg >> 1;
          b_reg      <= b_reg >> 1;
          cnt        <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_reg;

endmodule

// File: tb/tb_serial_lu.sv
// Directed self-checking bench for serial_lu (WIDTH=8).
module tb_serial_lu;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  serial_lu_if #(.WIDTH(8)) bus ();

  serial_lu #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one start and follow it to done, checking latency, busy length and result.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] opv,
                        input logic [7:0] exp, input string tag);
    int lat;
    int bc;
    bus.a = av; bus.b = bv; bus.op = opv; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bc  = bus.busy ? 1 : 0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done) begin lat = i; break; end
      if (bus.busy) bc++;
    end
    check({tag, "_latency"}, lat, 8);
    check({tag, "_busy_cycles"}, bc, 8);
    check({tag, "_result"}, bus.result, exp);
    check({tag, "_busy_at_done"}, bus.busy, 1'b0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, bus.done, 1'b0);
  endtask

  initial begin
    int lat;
    int dcnt;
    int pulses;
    int pulse_at[3];
    n_checks = 0;
    n_fail   = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.op    = 2'b00;
    #1;
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_result", bus.result, 8'h00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Four ops on the same operands.
    run_op(8'hCC, 8'hAA, 2'b00, 8'h88, "and");
    run_op(8'hCC, 8'hAA, 2'b01, 8'hEE, "or");
    run_op(8'hCC, 8'hAA, 2'b10, 8'h66, "xor");
    run_op(8'hCC, 8'hAA, 2'b11, 8'h33, "nota");

    // Start during SHIFT is ignored.
    bus.a = 8'hF0; bus.b = 8'h0F; bus.op = 2'b00; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin
        bus.a = 8'hFF; bus.b = 8'hFF; bus.op = 2'b01; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done) begin lat = i; break; end
    end
    bus.start = 1'b0;
    check("ignore_latency", lat, 8);
    check("ignore_result", bus.result, 8'h00);
    @(negedge clk);
    check("ignore_no_restart", bus.busy, 1'b0);
    @(negedge clk);

    // Reset mid-operation aborts without a done pulse.
    bus.a = 8'h81; bus.b = 8'h00; bus.op = 2'b01; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", bus.busy, 1'b1);
    reset = 1'b1;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_result", bus.result, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    run_op(8'h81, 8'h00, 2'b01, 8'h81, "after_abort");

    // Start held high: back-to-back operations every WIDTH+2 cycles.
    bus.a = 8'h5A; bus.b = 8'hFF; bus.op = 2'b10; bus.start = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40 && pulses < 3; i++) begin
      @(negedge clk);
      if (bus.done) begin
        pulse_at[pulses] = i;
        pulses++;
        check("held_result", bus.result, 8'hA5);
      end
    end
    bus.start = 1'b0;
    check("held_pulses", pulses, 3);
    if (pulses == 3) begin
      check("held_spacing1", pulse_at[1] - pulse_at[0], 10);
      check("held_spacing2", pulse_at[2] - pulse_at[1], 10);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.busy && !bus.done) break;
    end
    @(negedge clk);
    check("held_idle", bus.busy, 1'b0);

    // Input changes during SHIFT have no effect.
    bus.a = 8'h3C; bus.b = 8'h00; bus.op = 2'b11; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      bus.a  = 8'($urandom);
      bus.b  = 8'($urandom);
      bus.op = 2'($urandom);
      @(negedge clk);
      if (bus.done) begin lat = i; break; end
    end
    check("stable_latency", lat, 8);
    check("stable_result", bus.result, 8'hC3);
    repeat (5) @(negedge clk);
    check("stable_hold", bus.result, 8'hC3);
    check("stable_idle_done", bus.done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
